// File: rtl/aes_pkg.sv
// Shared AES-128 tables and round helpers (S-box, rcon, byte/column transforms, key schedule step).
// Byte 0 of every 128-bit word sits in bits [127:120], column-major as in FIPS-197.
package aes_pkg;

  typedef enum logic [1:0] {
    PH_START,
    PH_ROUND,
    PH_FINAL
  } phase_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon_of(logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(logic [127:0] rk, logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round plus the matching on-the-fly key expansion step.
// The final round skips MixColumns.
import aes_pkg::*;

module aes_round (
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         is_final,
  output logic [127:0] next_state,
  output logic [127:0] next_rk
);

  logic [127:0] shifted;

  always_comb begin
    next_rk    = key_step(rk, rcon);
    shifted    = shift_rows(sub_bytes(state));
    next_state = (is_final ? shifted : mix_columns(shifted)) ^ next_rk;
  end

endmodule

// File: rtl/aes_main.sv
// Free-running iterative AES-128 encryptor: 1 START cycle + 10 rounds per block.
// Define AES_DONE_EN to add a one-cycle `done` pulse after each data_out update.
import aes_pkg::*;

module aes_main (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic         newKey,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] data_out
`ifdef AES_DONE_EN
  ,
  output logic         done
`endif
);

  logic [127:0] state;
  logic [127:0] rk;
  logic [3:0]   rnd;
  logic [127:0] next_state;
  logic [127:0] next_rk;
  phase_e       phase;

  // rnd values above 10 are unreachable; treating them as START self-recovers.
  always_comb begin
    phase = PH_START;
    if (rnd == 4'd10)
      phase = PH_FINAL;
    else if (rnd >= 4'd1 && rnd <= 4'd9)
      phase = PH_ROUND;
  end

  aes_round u_round (
    .state      (state),
    .rk         (rk),
    .rcon       (rcon_of(rnd)),
    .is_final   (phase == PH_FINAL),
    .next_state (next_state),
    .next_rk    (next_rk)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= '0;
      rk       <= '0;
      rnd      <= '0;
      data_out <= '0;
`ifdef AES_DONE_EN
      done     <= 1'b0;
`endif
    end else begin
`ifdef AES_DONE_EN
      done <= 1'b0;
`endif
      if (newKey) begin
        rnd <= '0;
      end else begin
        case (phase)
          PH_START: begin
            state <= data_in ^ key;
            rk    <= key;
            rnd   <= 4'd1;
          end
          PH_ROUND: begin
            state <= next_state;
            rk    <= next_rk;
            rnd   <= rnd + 4'd1;
          end
          default: begin
            data_out <= next_state;
            rnd      <= '0;
`ifdef AES_DONE_EN
            done     <= 1'b1;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_main.sv
// Self-checking bench for aes_main: FIPS-197 known answers plus random blocks
// checked against a byte-array AES model whose S-box is derived from GF(2^8) inverses.
module tb_aes_main;

  logic         CLK100MHZ;
  logic         CPU_RESETN;
  logic         newKey;
  logic [127:0] data_in;
  logic [127:0] key;
  logic [127:0] data_out;
`ifdef AES_DONE_EN
  logic         done;
`endif

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] refSbox [256];

  aes_main dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .newKey     (newKey),
    .data_in    (data_in),
    .key        (key),
    .data_out   (data_out)
`ifdef AES_DONE_EN
    ,
    .done       (done)
`endif
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      refSbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook AES-128: full key schedule first, then rounds on a 16-byte array.
  function automatic logic [127:0] refEncrypt(logic [127:0] pt, logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [176];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, first, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127 - 8*i -: 8];
      w[i] = k[127 - 8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
      if (i % 4 == 0) begin
        first  = tmp[0];
        tmp[0] = refSbox[tmp[1]] ^ rc;
        tmp[1] = refSbox[tmp[2]];
        tmp[2] = refSbox[tmp[3]];
        tmp[3] = refSbox[first];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
    end
    for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[j];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) s[j] = refSbox[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4*c] = s[row + 4*((c + row) % 4)];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        s = t;
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[16*r + j];
    end
    out = '0;
    for (int j = 0; j < 16; j++) out[127 - 8*j -: 8] = s[j];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
    data_in = pt;
    key     = k;
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Caller is positioned just after an edge; the next edge must be a START edge.
  task automatic runBlock(input string tag, input logic [127:0] pt, input logic [127:0] k,
                          input logic [127:0] expCt, input logic [127:0] prevCt,
                          input bit scramble, input bit checkRk, input logic [127:0] rk1);
    applyStimulus(pt, k);
    tick();
    if (scramble) applyStimulus(rand128(), rand128());
    tick();
    if (checkRk) checkOutput({tag, "_rk1"}, dut.rk, rk1);
    repeat (8) tick();
    checkOutput({tag, "_hold"}, data_out, prevCt);
`ifdef AES_DONE_EN
    checkOutput({tag, "_done_low"}, {127'b0, done}, 128'd0);
`endif
    tick();
    checkOutput({tag, "_ct"}, data_out, expCt);
`ifdef AES_DONE_EN
    checkOutput({tag, "_done_pulse"}, {127'b0, done}, 128'd1);
`endif
  endtask

  initial begin
    logic [127:0] pt, k, expCt, prevCt;
    buildSbox();
    CPU_RESETN = 1'b0;
    newKey     = 1'b0;
    applyStimulus('0, '0);
    repeat (3) tick();
    checkOutput("reset_dout", data_out, 128'd0);
`ifdef AES_DONE_EN
    checkOutput("reset_done", {127'b0, done}, 128'd0);
`endif
    CPU_RESETN = 1'b1;

    runBlock("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'd0, 1'b1, 1'b0, 128'd0);
    runBlock("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3925841d02dc09fbdc118597196a0b32, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             1'b0, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
    runBlock("zero", 128'd0, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
             128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b0, 128'd0);
    prevCt = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    for (int i = 0; i < 6; i++) begin
      pt    = rand128();
      k     = rand128();
      expCt = refEncrypt(pt, k);
      runBlock($sformatf("rand%0d", i), pt, k, expCt, prevCt, 1'($urandom_range(0, 1)), 1'b0, 128'd0);
      prevCt = expCt;
    end

    // Abort a block at round 5 with a 3-cycle newKey pulse.
    applyStimulus(rand128(), rand128());
    tick();
    repeat (4) tick();
    newKey = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef AES_DONE_EN
      checkOutput($sformatf("newkey_done%0d", i), {127'b0, done}, 128'd0);
`endif
    end
    checkOutput("newkey_hold", data_out, prevCt);
    newKey = 1'b0;
    pt     = rand128();
    k      = rand128();
    expCt  = refEncrypt(pt, k);
    runBlock("after_newkey", pt, k, expCt, prevCt, 1'b1, 1'b0, 128'd0);
    prevCt = expCt;

    // Reset in the middle of a block clears data_out at once.
    applyStimulus(rand128(), rand128());
    tick();
    repeat (4) tick();
    CPU_RESETN = 1'b0;
    #1;
    checkOutput("midreset_dout", data_out, 128'd0);
`ifdef AES_DONE_EN
    checkOutput("midreset_done", {127'b0, done}, 128'd0);
`endif
    tick();
    CPU_RESETN = 1'b1;
    pt    = rand128();
    k     = rand128();
    expCt = refEncrypt(pt, k);
    runBlock("after_reset", pt, k, expCt, 128'd0, 1'b0, 1'b0, 128'd0);
    prevCt = expCt;

    pt    = rand128();
    k     = rand128();
    expCt = refEncrypt(pt, k);
    runBlock("final", pt, k, expCt, prevCt, 1'b1, 1'b0, 128'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
